// File: rtl/mux_scan_sequencer.sv
// Round-robin scan controller for a 4:1 analog mux: break-before-make dead time,
// settle interval and a sample request/acknowledge handshake per enabled channel.
module mux_scan_sequencer #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned DEAD_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               start,
  input  logic               single_shot,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [DEAD_W-1:0]  dead_cycles,
  output logic [SEL_W-1:0]   sel,
  output logic               mux_en,
  output logic               sample_req,
  input  logic               sample_ack,
  output logic [SEL_W-1:0]   ch_id,
  output logic               busy,
  output logic               scan_done
);

  localparam int unsigned CNT_W = (DWELL_W > DEAD_W) ? DWELL_W : DEAD_W;

  typedef enum logic [1:0] {StIdle, StDead, StSettle, StSample} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ch_id_q, ch_id_d;
  logic             scan_done_q, scan_done_d;
  logic             mux_en_q, mux_en_d;
  logic             sample_req_q, sample_req_d;
  logic             busy_q, busy_d;

  logic [SEL_W-1:0] lowest_ch;
  logic [SEL_W-1:0] above_ch;
  logic             above_found;
  logic [CNT_W-1:0] dead_ld;
  logic [CNT_W-1:0] dwell_ld;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sel_q        <= '0;
      ch_id_q      <= '0;
      scan_done_q  <= 1'b0;
      mux_en_q     <= 1'b0;
      sample_req_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      ch_id_q      <= ch_id_d;
      scan_done_q  <= scan_done_d;
      mux_en_q     <= mux_en_d;
      sample_req_q <= sample_req_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state, counter and channel selection
  always_comb begin
    lowest_ch   = '0;
    above_ch    = '0;
    above_found = 1'b0;
    // Descending scan so the last hit is the lowest qualifying channel.
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        lowest_ch = SEL_W'(i);
        if (i > int'(sel_q)) begin
          above_found = 1'b1;
          above_ch    = SEL_W'(i);
        end
      end
    end

    // Counters hold remaining cycles minus one; a zero setting behaves as one.
    dead_ld  = (dead_cycles == '0) ? '0 : CNT_W'(dead_cycles) - CNT_W'(1);
    dwell_ld = (dwell_cycles == '0) ? '0 : CNT_W'(dwell_cycles) - CNT_W'(1);

    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    ch_id_d     = ch_id_q;
    scan_done_d = 1'b0;

    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && (ch_mask != '0)) begin
            state_d = StDead;
            sel_d   = lowest_ch;
            cnt_d   = dead_ld;
          end
        end
        StDead: begin
          if (cnt_q == '0) begin
            state_d = StSettle;
            cnt_d   = dwell_ld;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_d = StSample;
            ch_id_d = sel_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StSample: begin
          if (sample_ack) begin
            if (ch_mask == '0) begin
              state_d     = StIdle;
              scan_done_d = 1'b1;
            end else if (above_found) begin
              state_d = StDead;
              sel_d   = above_ch;
              cnt_d   = dead_ld;
            end else begin
              scan_done_d = 1'b1;
              if (single_shot) begin
                state_d = StIdle;
              end else begin
                state_d = StDead;
                sel_d   = lowest_ch;
                cnt_d   = dead_ld;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs follow the upcoming state so they can be registered alongside it.
  always_comb begin
    mux_en_d     = (state_d == StSettle) || (state_d == StSample);
    sample_req_d = (state_d == StSample);
    busy_d       = (state_d != StIdle);
  end

  assign sel        = sel_q;
  assign ch_id      = ch_id_q;
  assign mux_en     = mux_en_q;
  assign sample_req = sample_req_q;
  assign busy       = busy_q;
  assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: timeline model of channel visits checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       single_shot = 1'b0;
  logic [3:0] ch_mask = 4'b0;
  logic [7:0] dwell_cycles = 8'd0;
  logic [3:0] dead_cycles = 4'd0;
  logic       sample_ack = 1'b0;
  logic [1:0] sel;
  logic       mux_en;
  logic       sample_req;
  logic [1:0] ch_id;
  logic       busy;
  logic       scan_done;

  mux_scan_sequencer #(
    .NUM_CH (4),
    .SEL_W  (2),
    .DWELL_W(8),
    .DEAD_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .start       (start),
    .single_shot (single_shot),
    .ch_mask     (ch_mask),
    .dwell_cycles(dwell_cycles),
    .dead_cycles (dead_cycles),
    .sel         (sel),
    .mux_en      (mux_en),
    .sample_req  (sample_req),
    .sample_ack  (sample_ack),
    .ch_id       (ch_id),
    .busy        (busy),
    .scan_done   (scan_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a visit starts at cycle m_start; the first m_d cycles are dead time,
  // the next m_w cycles settle, and sampling lasts from then until an ack.
  int cyc = 0;
  bit m_valid = 1'b0;
  bit m_act = 1'b0;
  bit m_done = 1'b0;
  int m_sel = 0;
  int m_start = 0;
  int m_d = 1;
  int m_w = 1;

  function automatic int lowest(input logic [3:0] m);
    int r;
    r = -1;
    for (int i = 3; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction

  function automatic int above(input logic [3:0] m, input int c);
    int r;
    r = -1;
    for (int i = 3; i > c; i--) if (m[i]) r = i;
    return r;
  endfunction

  function automatic int atleast1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge clk) begin
    int age;
    int nx;
    bit dn;
    dn  = 1'b0;
    age = cyc - m_start;
    if (rst) begin
      m_act   = 1'b0;
      m_sel   = 0;
      m_valid = 1'b1;
    end else if (!enable) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (start && ch_mask != 4'b0) begin
        m_act   = 1'b1;
        m_sel   = lowest(ch_mask);
        m_start = cyc + 1;
        m_d     = atleast1(int'(dead_cycles));
      end
    end else begin
      if (age == m_d - 1) m_w = atleast1(int'(dwell_cycles));
      if (age >= m_d + m_w && sample_ack) begin
        nx = above(ch_mask, m_sel);
        if (ch_mask == 4'b0) begin
          m_act = 1'b0;
          dn    = 1'b1;
        end else if (nx >= 0) begin
          m_sel   = nx;
          m_start = cyc + 1;
          m_d     = atleast1(int'(dead_cycles));
        end else begin
          dn = 1'b1;
          if (single_shot) begin
            m_act = 1'b0;
          end else begin
            m_sel   = lowest(ch_mask);
            m_start = cyc + 1;
            m_d     = atleast1(int'(dead_cycles));
          end
        end
      end
    end
    m_done = dn;
    cyc++;
  end

  logic [1:0] prev_sel = 2'd0;

  always @(negedge clk) begin
    int age;
    bit e_men;
    bit e_req;
    if (m_valid) begin
      age   = cyc - m_start;
      e_men = m_act && (age >= m_d);
      e_req = m_act && (age >= m_d + m_w);
      chk("busy", 32'(busy), 32'(m_act));
      chk("mux_en", 32'(mux_en), 32'(e_men));
      chk("sample_req", 32'(sample_req), 32'(e_req));
      chk("scan_done", 32'(scan_done), 32'(m_done));
      if (m_act) chk("sel", 32'(sel), 32'(m_sel));
      if (e_req) chk("ch_id", 32'(ch_id), 32'(m_sel));
      if (mux_en) chk("bbm_sel_stable", 32'(sel), 32'(prev_sel));
      if (sample_req) chk("req_implies_mux_en", 32'(mux_en), 32'd1);
    end
    prev_sel = sel;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    enable     = 1'b0;
    start      = 1'b0;
    sample_ack = 1'b0;
    step();
    enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("rst_sel", 32'(sel), 0);
    chk("rst_mux_en", 32'(mux_en), 0);
    chk("rst_req", 32'(sample_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(scan_done), 0);
    chk("rst_ch_id", 32'(ch_id), 0);
    rst    = 1'b0;
    enable = 1'b1;
    step();

    // Basic single-shot round over channels 0, 1, 3
    ch_mask = 4'b1011; dead_cycles = 4'd2; dwell_cycles = 8'd3;
    sample_ack = 1'b1; single_shot = 1'b1; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      start = 1'b0;
      case (c)
        1:  begin chk("b1_sel", 32'(sel), 0); chk("b1_men", 32'(mux_en), 0);
                  chk("b1_busy", 32'(busy), 1); end
        2:  begin chk("b2_sel", 32'(sel), 0); chk("b2_men", 32'(mux_en), 0); end
        3:  chk("b3_men", 32'(mux_en), 1);
        5:  begin chk("b5_men", 32'(mux_en), 1); chk("b5_req", 32'(sample_req), 0); end
        6:  begin chk("b6_req", 32'(sample_req), 1); chk("b6_id", 32'(ch_id), 0); end
        7:  begin chk("b7_sel", 32'(sel), 1); chk("b7_men", 32'(mux_en), 0);
                  chk("b7_req", 32'(sample_req), 0); end
        12: begin chk("b12_req", 32'(sample_req), 1); chk("b12_id", 32'(ch_id), 1); end
        13: begin chk("b13_sel", 32'(sel), 3); chk("b13_men", 32'(mux_en), 0); end
        18: begin chk("b18_req", 32'(sample_req), 1); chk("b18_id", 32'(ch_id), 3); end
        19: begin chk("b19_done", 32'(scan_done), 1); chk("b19_busy", 32'(busy), 0); end
        20: chk("b20_done", 32'(scan_done), 0);
        default: ;
      endcase
    end

    // Continuous, single channel, zero dead/dwell: 3-cycle period
    ch_mask = 4'b0100; dead_cycles = 4'd0; dwell_cycles = 8'd0;
    single_shot = 1'b0; sample_ack = 1'b1; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      start = 1'b0;
      case (c)
        1:  begin chk("w1_men", 32'(mux_en), 0); chk("w1_sel", 32'(sel), 2); end
        2:  chk("w2_men", 32'(mux_en), 1);
        3:  chk("w3_req", 32'(sample_req), 1);
        4:  begin chk("w4_done", 32'(scan_done), 1); chk("w4_men", 32'(mux_en), 0);
                  chk("w4_sel", 32'(sel), 2); end
        5:  chk("w5_done", 32'(scan_done), 0);
        7:  chk("w7_done", 32'(scan_done), 1);
        10: chk("w10_done", 32'(scan_done), 1);
        default: ;
      endcase
    end
    go_idle();

    // Reset during SETTLE on channel 2
    ch_mask = 4'b0100; dead_cycles = 4'd1; dwell_cycles = 8'd8;
    single_shot = 1'b1; sample_ack = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("r_men_pre", 32'(mux_en), 1);
    chk("r_sel_pre", 32'(sel), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_sel", 32'(sel), 0);
    chk("r_men", 32'(mux_en), 0);
    chk("r_req", 32'(sample_req), 0);
    chk("r_busy", 32'(busy), 0);
    ch_mask = 4'b0110; start = 1'b1;
    step();
    start = 1'b0;
    chk("r_restart_sel", 32'(sel), 1);
    chk("r_restart_busy", 32'(busy), 1);
    go_idle();

    // Handshake stall: ack withheld 10 cycles in SAMPLE
    ch_mask = 4'b0001; dead_cycles = 4'd1; dwell_cycles = 8'd1;
    single_shot = 1'b1; sample_ack = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("h_req", 32'(sample_req), 1);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("h_stall_req", 32'(sample_req), 1);
      chk("h_stall_men", 32'(mux_en), 1);
      chk("h_stall_sel", 32'(sel), 0);
    end
    sample_ack = 1'b1;
    step();
    sample_ack = 1'b0;
    chk("h_req_drop", 32'(sample_req), 0);
    chk("h_done", 32'(scan_done), 1);
    chk("h_busy", 32'(busy), 0);

    // Enable dropped during DEAD
    ch_mask = 4'b0011; dead_cycles = 4'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    enable = 1'b0;
    step();
    chk("e_busy", 32'(busy), 0);
    chk("e_done", 32'(scan_done), 0);
    chk("e_men", 32'(mux_en), 0);
    chk("e_sel_hold", 32'(sel), 0);
    enable = 1'b1;

    // Start with an empty mask is ignored
    ch_mask = 4'b0000; start = 1'b1;
    step();
    start = 1'b0;
    chk("m0_busy", 32'(busy), 0);
    step();
    chk("m0_done", 32'(scan_done), 0);

    // Mask cleared in the ack cycle
    ch_mask = 4'b0010; dead_cycles = 4'd1; dwell_cycles = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("mc_req", 32'(sample_req), 1);
    chk("mc_sel", 32'(sel), 1);
    ch_mask = 4'b0000; sample_ack = 1'b1;
    step();
    sample_ack = 1'b0;
    chk("mc_busy", 32'(busy), 0);
    chk("mc_done", 32'(scan_done), 1);
    chk("mc_req_drop", 32'(sample_req), 0);
    step();
    chk("mc_done_pulse", 32'(scan_done), 0);

    // Random traffic checked by the model every cycle
    ch_mask = 4'b1111;
    for (int c = 0; c < 10000; c++) begin
      start      = ($urandom_range(0, 7) == 0);
      sample_ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) ch_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) dead_cycles = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) dwell_cycles = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 49) == 0) single_shot = ~single_shot;
      enable = ($urandom_range(0, 199) != 0);
      rst    = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;
    enable = 1'b1;
    start = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
